// File: rtl/level_meter_mc.sv
`timescale 1ns/1ps
// Multi-channel windowed power meter: per-channel mean square over 2^LOG2_WIN samples,
// converted to 0.5 dB steps with a peak-hold/decay tracker per channel.
module level_meter_mc #(
  parameter int DATA_W   = 16,
  parameter int CH       = 2,
  parameter int LOG2_WIN = 10,
  parameter int HOLD_WIN = 8,
  parameter int DECAY    = 3,
  localparam int CHW     = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] audio_data,
  input  logic [CHW-1:0]    audio_ch,
  input  logic              audio_valid,
  output logic              db_valid,
  output logic [CHW-1:0]    db_ch,
  output logic [9:0]        db_value,
  output logic [9:0]        peak_value,
  output logic              clip,
  output logic              silent
);

  localparam int SQ_W   = 2 * DATA_W;
  localparam int ACC_W  = SQ_W + LOG2_WIN;
  localparam int HOLD_W = (HOLD_WIN > 0) ? $clog2(HOLD_WIN + 1) : 1;
  localparam int P_W    = 6;
  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [SQ_W-1:0] w_prod;
  logic [SQ_W-1:0]        w_sq;
  logic                   w_full;

  assign w_prod = $signed(audio_data) * $signed(audio_data);
  assign w_sq   = $unsigned(w_prod);
  assign w_full = (audio_data == MAX_POS) || (audio_data == MIN_NEG);

  // Stage 1: window mean square captured on the completing sample
  logic              r_s1_valid;
  logic [CHW-1:0]    r_s1_ch;
  logic [SQ_W-1:0]   r_s1_ms;
  logic              r_s1_clip;

  logic [ACC_W-1:0]  w_sum      [CH];
  logic              w_done     [CH];
  logic              w_clip_win [CH];
  logic [9:0]        w_peak     [CH];
  logic [HOLD_W-1:0] w_hold     [CH];
  logic [9:0]        w_peak_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic [ACC_W-1:0]    r_acc;
    logic [LOG2_WIN-1:0] r_cnt;
    logic                r_clip;
    logic [9:0]          r_peak;
    logic [HOLD_W-1:0]   r_hold;
    logic                w_hit;
    logic                w_upd;

    // Out-of-range channel indices never match any gi, so they leave state untouched
    assign w_hit          = audio_valid && (audio_ch == CHW'(gi));
    assign w_upd          = r_s1_valid && (r_s1_ch == CHW'(gi));
    assign w_sum[gi]      = r_acc + ACC_W'(w_sq);
    assign w_done[gi]     = w_hit && (&r_cnt);
    assign w_clip_win[gi] = r_clip | w_full;
    assign w_peak[gi]     = r_peak;
    assign w_hold[gi]     = r_hold;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_acc  <= '0;
        r_cnt  <= '0;
        r_clip <= 1'b0;
        r_peak <= '0;
        r_hold <= '0;
      end else begin
        if (w_hit) begin
          r_cnt <= r_cnt + LOG2_WIN'(1);
          if (&r_cnt) begin
            r_acc  <= '0;
            r_clip <= 1'b0;
          end else begin
            r_acc  <= w_sum[gi];
            r_clip <= w_clip_win[gi];
          end
        end
        if (w_upd) begin
          r_peak <= w_peak_nxt;
          r_hold <= w_hold_nxt;
        end
      end
    end
  end

  logic            w_done_any;
  logic [SQ_W-1:0] w_ms_d;
  logic            w_clip_d;

  always_comb begin
    w_done_any = 1'b0;
    w_ms_d     = '0;
    w_clip_d   = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (w_done[i]) begin
        w_done_any = 1'b1;
        w_ms_d     = w_sum[i][ACC_W-1:LOG2_WIN];
        w_clip_d   = w_clip_win[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_ch    <= '0;
      r_s1_ms    <= '0;
      r_s1_clip  <= 1'b0;
    end else begin
      r_s1_valid <= w_done_any;
      if (w_done_any) begin
        r_s1_ch   <= audio_ch;
        r_s1_ms   <= w_ms_d;
        r_s1_clip <= w_clip_d;
      end
    end
  end

  // Log stage: L = 8*p + f, where f is the 3 bits after the leading one
  logic [P_W-1:0] w_p;
  logic [P_W-1:0] w_shift;
  logic [2:0]     w_f;
  logic [8:0]     w_l;
  logic [9:0]     w_db;
  logic           w_silent;

  always_comb begin
    w_p = '0;
    for (int i = 0; i < SQ_W; i++) begin
      if (r_s1_ms[i]) w_p = P_W'(i);
    end
  end

  assign w_shift  = P_W'(SQ_W - 1) - w_p;
  assign w_f      = 3'((r_s1_ms << w_shift) >> (SQ_W - 4));
  assign w_l      = {w_p[5:0], w_f};
  assign w_silent = (r_s1_ms == '0);
  assign w_db     = w_silent ? 10'd0 : 10'((12'(w_l) * 12'd3) >> 2);

  logic [9:0]        w_pk_cur;
  logic [HOLD_W-1:0] w_hold_cur;
  logic [9:0]        w_pk_dec;

  always_comb begin
    w_pk_cur   = '0;
    w_hold_cur = '0;
    for (int i = 0; i < CH; i++) begin
      if (r_s1_ch == CHW'(i)) begin
        w_pk_cur   = w_peak[i];
        w_hold_cur = w_hold[i];
      end
    end
  end

  assign w_pk_dec = (w_pk_cur > 10'(DECAY)) ? (w_pk_cur - 10'(DECAY)) : 10'd0;

  always_comb begin
    w_peak_nxt = w_pk_cur;
    w_hold_nxt = w_hold_cur;
    if (w_db >= w_pk_cur) begin
      w_peak_nxt = w_db;
      w_hold_nxt = HOLD_W'(HOLD_WIN);
    end else if (w_hold_cur != '0) begin
      w_hold_nxt = w_hold_cur - HOLD_W'(1);
    end else begin
      w_peak_nxt = (w_db > w_pk_dec) ? w_db : w_pk_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_valid   <= 1'b0;
      db_ch      <= '0;
      db_value   <= '0;
      peak_value <= '0;
      clip       <= 1'b0;
      silent     <= 1'b0;
    end else begin
      db_valid <= r_s1_valid;
      if (r_s1_valid) begin
        db_ch      <= r_s1_ch;
        db_value   <= w_db;
        peak_value <= w_peak_nxt;
        clip       <= r_s1_clip;
        silent     <= w_silent;
      end
    end
  end

endmodule

// File: tb/tb_level_meter_mc.sv
`timescale 1ns/1ps
// Scoreboard bench for level_meter_mc with a 4-sample window; a second instance
// with CH=3 exercises the out-of-range channel index.
module tb_level_meter_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] audio_data;
  logic        audio_ch;
  logic        audio_valid;
  logic        db_valid;
  logic        db_ch;
  logic [9:0]  db_value;
  logic [9:0]  peak_value;
  logic        clip;
  logic        silent;

  logic [15:0] d3_data;
  logic [1:0]  d3_ch;
  logic        d3_valid;
  logic        d3_db_valid;
  logic [1:0]  d3_db_ch;
  logic [9:0]  d3_db_value;
  logic [9:0]  d3_peak;
  logic        d3_clip;
  logic        d3_silent;

  level_meter_mc #(.DATA_W(16), .CH(2), .LOG2_WIN(2), .HOLD_WIN(2), .DECAY(3)) u_dut (
    .clk(clk), .rst(rst), .audio_data(audio_data), .audio_ch(audio_ch),
    .audio_valid(audio_valid), .db_valid(db_valid), .db_ch(db_ch), .db_value(db_value),
    .peak_value(peak_value), .clip(clip), .silent(silent)
  );

  level_meter_mc #(.DATA_W(16), .CH(3), .LOG2_WIN(2), .HOLD_WIN(2), .DECAY(3)) u_dut3 (
    .clk(clk), .rst(rst), .audio_data(d3_data), .audio_ch(d3_ch),
    .audio_valid(d3_valid), .db_valid(d3_db_valid), .db_ch(d3_db_ch), .db_value(d3_db_value),
    .peak_value(d3_peak), .clip(d3_clip), .silent(d3_silent)
  );

  typedef struct {
    int         cyc;
    logic       ch;
    logic [9:0] db;
    logic [9:0] pk;
    logic       clp;
    logic       sil;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   d3_cnt = 0;
  logic [9:0] d3_last_db = '0;
  logic [9:0] d3_last_pk = '0;
  logic [1:0] d3_last_ch = '0;
  logic       d3_last_clip = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every db_valid pulse pops one expected result
  exp_t m_e;
  always @(negedge clk) begin
    if (db_valid) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_db_valid cyc=%0d ch=%0d db=%0d pk=%0d", cyc, db_ch, db_value, peak_value);
      end else begin
        m_e = sb.pop_front();
        if (cyc != m_e.cyc || db_ch != m_e.ch || db_value != m_e.db || peak_value != m_e.pk ||
            clip != m_e.clp || silent != m_e.sil) begin
          miscompares++;
          $display("FAIL db_result got cyc=%0d ch=%0d db=%0d pk=%0d clip=%0d silent=%0d exp cyc=%0d ch=%0d db=%0d pk=%0d clip=%0d silent=%0d",
                   cyc, db_ch, db_value, peak_value, clip, silent,
                   m_e.cyc, m_e.ch, m_e.db, m_e.pk, m_e.clp, m_e.sil);
        end else begin
          $display("ok   db_result cyc=%0d ch=%0d db=%0d pk=%0d clip=%0d silent=%0d",
                   cyc, db_ch, db_value, peak_value, clip, silent);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (d3_db_valid) begin
      d3_cnt++;
      d3_last_db   = d3_db_value;
      d3_last_pk   = d3_peak;
      d3_last_ch   = d3_db_ch;
      d3_last_clip = d3_clip;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", name, got, expv);
    end else begin
      $display("ok   %s value=%0d", name, got);
    end
  endtask

  task automatic drive(input logic ch, input logic [15:0] d);
    @(negedge clk);
    audio_valid = 1'b1;
    audio_ch    = ch;
    audio_data  = d;
  endtask

  task automatic idle();
    @(negedge clk);
    audio_valid = 1'b0;
    d3_valid    = 1'b0;
  endtask

  task automatic push(input logic ch, input logic [9:0] db, input logic [9:0] pk,
                      input logic clp, input logic sil);
    exp_t e;
    e.cyc = cyc + 2;
    e.ch  = ch;
    e.db  = db;
    e.pk  = pk;
    e.clp = clp;
    e.sil = sil;
    sb.push_back(e);
  endtask

  task automatic send_win(input logic ch, input logic [15:0] d, input logic [9:0] db,
                          input logic [9:0] pk, input logic clp, input logic sil);
    repeat (3) drive(ch, d);
    drive(ch, d);
    push(ch, db, pk, clp, sil);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout pending=%0d exp=0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset(input logic with_valid);
    @(negedge clk);
    rst         = 1'b1;
    audio_valid = with_valid;
    audio_ch    = 1'b0;
    audio_data  = 16'h7fff;
    d3_valid    = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_outputs", 32'({db_valid, db_ch, db_value, peak_value, clip, silent}), 32'd0);
    @(negedge clk);
    rst         = 1'b0;
    audio_valid = 1'b0;
  endtask

  task automatic d3_drive(input logic [1:0] ch, input logic [15:0] d);
    @(negedge clk);
    d3_valid = 1'b1;
    d3_ch    = ch;
    d3_data  = d;
  endtask

  logic [9:0] pk_seq [4];

  initial begin
    rst = 1'b1; audio_valid = 1'b0; audio_ch = 1'b0; audio_data = '0;
    d3_valid = 1'b0; d3_ch = '0; d3_data = '0;
    pk_seq[0] = 10'd96; pk_seq[1] = 10'd96; pk_seq[2] = 10'd93; pk_seq[3] = 10'd90;
    repeat (3) @(negedge clk);
    chk("initial_reset_outputs", 32'({db_valid, db_ch, db_value, peak_value, clip, silent}), 32'd0);
    rst = 1'b0;

    // 256^2 window, then four silent windows to walk the hold and decay
    send_win(1'b0, 16'd256, 10'd96, 10'd96, 1'b0, 1'b0);
    for (int w = 0; w < 4; w++) send_win(1'b0, 16'd0, 10'd0, pk_seq[w], 1'b0, 1'b1);
    idle();
    drain();
    chk("hold_db_value", 32'(db_value), 32'd0);
    chk("hold_peak_value", 32'(peak_value), 32'd90);

    // ch1: silence then full-scale negative
    send_win(1'b1, 16'd0, 10'd0, 10'd0, 1'b0, 1'b1);
    send_win(1'b1, 16'h8000, 10'd180, 10'd180, 1'b1, 1'b0);
    idle();
    drain();

    // Interleaved channels completing on consecutive cycles
    do_reset(1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 16'd1000);
      if (k == 3) push(1'b0, 10'd119, 10'd119, 1'b0, 1'b0);
      drive(1'b1, 16'h7fff);
      if (k == 3) push(1'b1, 10'd179, 10'd179, 1'b1, 1'b0);
    end
    idle();
    drain();

    // Completing sample immediately followed by reset: result must vanish
    repeat (3) drive(1'b1, 16'd5);
    drive(1'b1, 16'd5);
    do_reset(1'b0);
    idle();
    drain();

    // Partial window, reset with valid held high, then a fresh window of 1s
    drive(1'b0, 16'd1000);
    drive(1'b0, 16'd1000);
    do_reset(1'b1);
    send_win(1'b0, 16'd1, 10'd0, 10'd0, 1'b0, 1'b0);
    idle();
    drain();

    // CH=3 instance: channel index 3 must be ignored entirely
    d3_drive(2'd0, 16'd256);
    d3_drive(2'd3, 16'h8000);
    d3_drive(2'd3, 16'h8000);
    d3_drive(2'd0, 16'd256);
    d3_drive(2'd3, 16'h7fff);
    d3_drive(2'd3, 16'h7fff);
    d3_drive(2'd0, 16'd256);
    d3_drive(2'd3, 16'd0);
    d3_drive(2'd0, 16'd256);
    idle();
    repeat (6) @(negedge clk);
    chk("ch3_db_valid_count", 32'(d3_cnt), 32'd1);
    chk("ch3_db_value", 32'(d3_last_db), 32'd96);
    chk("ch3_db_ch", 32'(d3_last_ch), 32'd0);
    chk("ch3_clip", 32'(d3_last_clip), 32'd0);
    chk("ch3_peak", 32'(d3_last_pk), 32'd96);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout cyc=%0d exp=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/level_meter_mc.md
LEVEL_METER_MC -- requirements
Module: level_meter_mc

Interface
REQ-001 Parameter DATA_W, default 16: signed sample width, legal range 8..20.
REQ-002 Parameter CH, default 2: number of interleaved channels, legal range 1..8.
REQ-003 Parameter LOG2_WIN, default 10: log2 of the per-channel window length in samples, legal range 1..12.
REQ-004 Parameter HOLD_WIN, default 8: number of windows a new peak is held before decay starts.
REQ-005 Parameter DECAY, default 3: peak decay step per window, in 0.5 dB units.
REQ-006 Port clk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-007 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 Port audio_data, input, DATA_W bits: signed two's-complement sample.
REQ-009 Port audio_ch, input, CHW = max(1, clog2(CH)) bits: channel index of audio_data.
REQ-010 Port audio_valid, input, 1 bit: audio_data and audio_ch are qualified this cycle.
REQ-011 Port db_valid, output, 1 bit: one-cycle pulse; the db_* outputs are valid this cycle.
REQ-012 Port db_ch, output, CHW bits: channel index of the result.
REQ-013 Port db_value, output, 10 bits: window power level in 0.5 dB units relative to 1 LSB squared.
REQ-014 Port peak_value, output, 10 bits: peak-hold level of db_ch, in 0.5 dB units.
REQ-015 Port clip, output, 1 bit: a full-scale sample occurred in the reported window.
REQ-016 Port silent, output, 1 bit: the mean square of the reported window was 0.

Function
REQ-017 Each channel SHALL keep its own accumulator (2*DATA_W+LOG2_WIN bits), sample counter (LOG2_WIN bits), clip flag, peak register and hold counter.
REQ-018 On audio_valid with audio_ch < CH: sq = audio_data*audio_data (unsigned, 2*DATA_W bits) SHALL be added to that channel's accumulator, and its counter incremented.
REQ-019 A sample with audio_ch >= CH SHALL be ignored, with no state change.
REQ-020 The clip flag SHALL set when audio_data equals +(2^(DATA_W-1)-1) or -2^(DATA_W-1).
REQ-021 The window SHALL complete on the sample where the counter wraps from 2^LOG2_WIN-1 to 0; that sample SHALL be included in the window.
REQ-022 On window completion, ms = (acc + sq) >> LOG2_WIN; the accumulator and clip flag SHALL restart from 0, with no sample lost or double-counted.
REQ-023 Log stage: p = index of the leading one of ms; f = the 3 bits below the leading one, zero-padded when p < 3; L = 8*p + f.
REQ-024 db_value = (3*L) >> 2, truncated; db_value = 0 and silent = 1 when ms = 0; otherwise silent = 0.
REQ-025 db_valid SHALL assert exactly 2 cycles after the audio_valid cycle that completed the window.
REQ-026 The two-stage pipeline SHALL accept one completion per cycle, including back-to-back completions on different channels, with no stall and no loss.
REQ-027 Peak update, applied when the result is produced:
- if db_value >= peak: peak = db_value and hold = HOLD_WIN;
- else if hold > 0: hold decrements;
- else: peak = max(db_value, peak - DECAY), saturating at 0.
REQ-028 peak_value SHALL show the updated peak in the same cycle as db_valid.
REQ-029 clip SHALL report the window's clip flag, including the completing sample.
REQ-030 db_ch, db_value, peak_value, clip and silent SHALL hold their last values while db_valid = 0.

Reset
REQ-031 While rst = 1, all accumulators, counters, clip flags, peaks, hold counters and pipeline stages SHALL clear to 0.
REQ-032 While rst = 1, all outputs SHALL be 0.
REQ-033 Reset asserted mid-window SHALL discard partial windows and in-flight pipeline results; no db_valid SHALL occur for them.
REQ-034 audio_valid during reset SHALL be ignored; the first post-reset sample SHALL be sample 0 of a new window.

Verification (DATA_W=16, CH=2, LOG2_WIN=2, HOLD_WIN=2, DECAY=3)
REQ-035 4 samples of 256 on ch0 -> one db_valid, 2 cycles after the 4th sample: db_ch=0, db_value=96, silent=0, clip=0, peak_value=96.
REQ-036 4 samples of 0 on ch1 -> db_value=0, silent=1; then 4 samples of -32768 on ch1 -> db_value=180, clip=1.
REQ-037 Interleaved ch0/ch1 samples, ending with consecutive completions -> two db_valid pulses on consecutive cycles, correct db_ch for each, no loss.
REQ-038 ch0 peak 96, followed by windows of 0 -> peak_value 96, 96, 96 (hold), then 93, 90.
REQ-039 2 samples on ch0, then rst for 1 cycle, then 4 samples of 1 -> exactly one db_valid, with db_value=0 and silent=0.
REQ-040 audio_ch=3 with audio_valid -> no state change and no db_valid.
